// File: rtl/simon_pkg.sv
// Shared types, defaults and one-hot helpers for the Simon Says switch front end.
package simon_pkg;

    localparam int DEF_N_SW            = 10;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HELD,
        ST_SEND,
        ST_WAIT_CLR
    } capture_state_t;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) idx = 5'(i);
        return idx;
    endfunction

endpackage

// File: rtl/simon_debounce.sv
// Two-flop synchroniser plus debounce: sw_db follows the synchronised switch
// bank once it has held one value for DEBOUNCE_CYCLES consecutive cycles.
module simon_debounce
    import simon_pkg::*;
#(
    parameter int N_SW            = DEF_N_SW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw,
    output logic [N_SW-1:0] sw_db
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [N_SW-1:0] sync1_q, sync2_q, db_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw;
            sync2_q <= sync1_q;
            // sync2 is about to change, or already matches: restart the count
            if ((sync1_q != sync2_q) || (sync2_q == db_q)) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_q  <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/simon_switch_capture.sv
// Switch-entry capture FSM: one raised switch per entry, index handed over on
// release via valid/ready. Idle timeout built only with SIMON_SWITCH_CAPTURE_TIMEOUT_EN.
module simon_switch_capture
    import simon_pkg::*;
#(
    parameter  int N_SW            = DEF_N_SW,
    parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter  int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W           = $clog2(N_SW)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on_off,
    input  logic [N_SW-1:0]  sw,
    input  logic             cmp_ready,
    output logic [N_SW-1:0]  led,
    output logic [IDX_W-1:0] to_cmp,
    output logic             to_cmp_valid,
    output logic             multi_err,
    output logic             timeout
);

    logic [N_SW-1:0]  sw_db;
    logic             db_zero, db_one;
    logic [IDX_W-1:0] db_idx;

    capture_state_t   state_q;
    logic [N_SW-1:0]  led_q, held_q;
    logic [IDX_W-1:0] idx_q, to_cmp_q;
    logic             valid_q, err_q;

    simon_debounce #(
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .sw_db (sw_db)
    );

    assign db_zero = (sw_db == '0);
    assign db_one  = is_onehot(32'(sw_db));
    assign db_idx  = IDX_W'(onehot_to_idx(32'(sw_db)));

`ifdef SIMON_SWITCH_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;
    logic          tmo_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            led_q    <= '0;
            held_q   <= '0;
            idx_q    <= '0;
            to_cmp_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SIMON_SWITCH_CAPTURE_TIMEOUT_EN
            tcnt_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            if (!on_off) begin
                // abort drops any pending entry without a transfer
                state_q <= ST_IDLE;
                led_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_ARMED;
                    ST_ARMED: begin
                        if (db_one) begin
                            held_q  <= sw_db;
                            idx_q   <= db_idx;
                            led_q   <= sw_db;
                            state_q <= ST_HELD;
                        end else if (!db_zero) begin
                            err_q   <= 1'b1;
                            state_q <= ST_WAIT_CLR;
                        end
                    end
                    ST_HELD: begin
                        if (db_zero) begin
                            to_cmp_q <= idx_q;
                            valid_q  <= 1'b1;
                            led_q    <= '0;
                            state_q  <= ST_SEND;
                        end else if (sw_db != held_q) begin
                            err_q   <= 1'b1;
                            led_q   <= '0;
                            state_q <= ST_WAIT_CLR;
                        end
                    end
                    ST_SEND: begin
                        if (cmp_ready) begin
                            valid_q <= 1'b0;
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_WAIT_CLR: begin
                        led_q <= '0;
                        if (db_zero) state_q <= ST_ARMED;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
`ifdef SIMON_SWITCH_CAPTURE_TIMEOUT_EN
            tmo_q <= 1'b0;
            if (on_off && (state_q == ST_ARMED) && db_zero) begin
                if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tcnt_q <= '0;
                    tmo_q  <= 1'b1;
                end else begin
                    tcnt_q <= tcnt_q + TW'(1);
                end
            end else begin
                tcnt_q <= '0;
            end
`endif
        end
    end

    assign led          = led_q;
    assign to_cmp       = to_cmp_q;
    assign to_cmp_valid = valid_q;
    assign multi_err    = err_q;

`ifdef SIMON_SWITCH_CAPTURE_TIMEOUT_EN
    assign timeout = tmo_q;
`else
    // constant 0; the comparison only keeps the parameter referenced
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: doc/simon_switch_capture.md
# simon_switch_capture

Parametrised switch-entry front end for the Simon Says datapath. It sits between the board slide switches and the sequence comparator. It synchronises and debounces an N-wide switch bank and accepts exactly one raised switch per entry. The switch's index is delivered to the comparator on release, through a valid/ready handshake. Multi-switch entries are flagged and discarded, and an optional idle timeout is reported.

## Interface
Parameters:
- N_SW, 10, number of switches/LEDs (2..32)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a new synchronised switch value (≥1)
- TIMEOUT_CYCLES, 1000, idle cycles in ARMED before `timeout` pulses (used only with the macro)
- Derived localparam IDX_W = $clog2(N_SW)

Ports:
- clk  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high; only the clk edge samples it
- on_off  in  1  game-enable; 0 aborts and idles the block
- sw  in  N_SW  raw asynchronous switch levels
- cmp_ready  in  1  comparator can accept an index this cycle
- led  out  N_SW  one-hot echo of the accepted switch
- to_cmp  out  IDX_W  index (0..N_SW-1) of the accepted switch
- to_cmp_valid  out  1  to_cmp holds a valid entry
- multi_err  out  1  one-cycle pulse: more than one switch raised
- timeout  out  1  one-cycle pulse: idle timeout (tied 0 without the macro)

## Operation
- Input path: 2-flop synchroniser, then a debounce counter. `sw_db` updates to the synchronised value once it has been unchanged for DEBOUNCE_CYCLES consecutive cycles. Any change restarts the count.
- FSM states are IDLE, ARMED, HELD, SEND and WAIT_CLR. From any state, on_off=0 moves to IDLE on the next cycle.
- IDLE: led=0, valid=0. Go to ARMED when on_off=1.
- ARMED, sw_db==0: stay in ARMED.
- ARMED, exactly one bit set: latch its index and go to HELD. led becomes that one-hot value.
- ARMED, more than one bit set: pulse multi_err and go to WAIT_CLR.
- HELD: led holds the one-hot value.
  - sw_db==0: go to SEND with valid=1 and led=0.
  - sw_db differs from the latched one-hot and is nonzero: pulse multi_err, clear led, go to WAIT_CLR.
- SEND: valid stays high and to_cmp stays stable until the cycle where cmp_ready=1. On that cycle the transfer completes, valid drops next cycle, and the FSM goes to ARMED. Switch activity during SEND is ignored.
- WAIT_CLR: led=0. Go to ARMED when sw_db==0.
- Exception to the handshake rule: on_off=0 withdraws valid without a transfer, and the entry is lost.
- to_cmp keeps its last value outside SEND; consumers qualify it with valid.

## Timing
- Reset values: all outputs 0, FSM in IDLE, synchroniser flops 0, debounce and timeout counters 0, sw_db=0.
- A raw edge that stays stable reaches sw_db after 2 + DEBOUNCE_CYCLES cycles.
- FSM outputs are registered: led and valid change 1 cycle after the sw_db change.
- Minimum spacing is one entry per handshake; there is no buffering beyond the single held index.
- If reset is asserted mid-entry or mid-SEND, all state clears on that edge with no transfer.

## Configuration
- Macro: SIMON_SWITCH_CAPTURE_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in ARMED with sw_db==0. It clears on any other state or on nonzero sw_db.
  - At count == TIMEOUT_CYCLES-1, timeout pulses for 1 cycle, the counter clears, and the FSM stays in ARMED.
- Undefined: no counter is built, and timeout is constant 0. The port list is unchanged.

## Structure
- Shared package simon_pkg holds:
  - the FSM state enum `capture_state_t`
  - the `onehot_to_idx` and `is_onehot` functions
  - default-parameter constants
- One sub-module, simon_debounce (parameters N_SW and DEBOUNCE_CYCLES), contains the synchroniser and the debounce counter and outputs sw_db.

## Test plan
All scenarios use N_SW=10 and DEBOUNCE_CYCLES=4.
- Reset held for 2 cycles with random sw -> led=0, to_cmp=0, to_cmp_valid=0, multi_err=0, timeout=0.
- on_off=1, cmp_ready=1, sw=10'h008 for 12 cycles then 0 -> led=10'h008 7 cycles after the press. After release: led=0, valid high for 1 cycle with to_cmp=3.
- Same entry with cmp_ready=0 for 20 cycles, then 1 -> valid and to_cmp=3 held steady, valid low the cycle after ready.
- sw=10'h021 -> one multi_err pulse, led=0, no valid. Then sw=0 for 8 cycles, then sw=10'h200 and release -> to_cmp=9, valid.
- sw toggles between 10'h004 and 0 every 2 cycles for 16 cycles, then stays 0 -> led stays 0, no valid, no multi_err.
- Macro defined, TIMEOUT_CYCLES=50, on_off=1, sw=0 -> timeout pulses 50 cycles after entering ARMED, then every 50 cycles. Macro undefined -> timeout stays 0.
